// File: rtl/seven_seg_scan_driver.sv
// Eight-digit hex scanner for a multiplexed seven-segment display.
// Incoming values are double-buffered and only committed at frame boundaries.
module seven_seg_scan_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        load,
  input  logic [31:0] value,
  input  logic        blank_lz,
  input  logic        enable,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [7:0]  an,
  output logic        frame_done
);

  localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       digit_idx;
  logic [31:0]      pending;
  logic             pending_valid;
  logic [31:0]      disp;
  logic [6:0]       seg_act;
  logic [7:0]       an_act;

  logic             div_tick;
  logic             boundary;
  logic [31:0]      upper;
  logic [3:0]       nibble;
  logic             blank;
  logic [6:0]       pattern;

  assign div_tick = (div_cnt == DIV_LAST);
  assign boundary = div_tick && (digit_idx == 3'd7);

  always_ff @(posedge clk) begin
    if (clr) begin
      div_cnt   <= '0;
      digit_idx <= '0;
    end else if (div_tick) begin
      div_cnt   <= '0;
      digit_idx <= digit_idx + 3'd1;
    end else begin
      div_cnt   <= div_cnt + DIV_W'(1);
    end
  end

  // A load landing on the boundary itself goes straight to the display.
  always_ff @(posedge clk) begin
    if (clr) begin
      pending       <= '0;
      pending_valid <= 1'b0;
      disp          <= '0;
    end else if (boundary) begin
      if (load) begin
        disp          <= value;
        pending       <= value;
        pending_valid <= 1'b0;
      end else if (pending_valid) begin
        disp          <= pending;
        pending_valid <= 1'b0;
      end
    end else if (load) begin
      pending       <= value;
      pending_valid <= 1'b1;
    end
  end

  // upper holds the current digit and everything above it, so a zero
  // there means this digit is a leading zero.
  always_comb begin
    upper   = disp >> {digit_idx, 2'b00};
    nibble  = upper[3:0];
    blank   = blank_lz && (digit_idx != 3'd0) && (upper == 32'd0);
    pattern = 7'b0000000;
    case (nibble)
      4'h0: pattern = 7'b1111110;
      4'h1: pattern = 7'b0110000;
      4'h2: pattern = 7'b1101101;
      4'h3: pattern = 7'b1111001;
      4'h4: pattern = 7'b0110011;
      4'h5: pattern = 7'b1011011;
      4'h6: pattern = 7'b1011111;
      4'h7: pattern = 7'b1110000;
      4'h8: pattern = 7'b1111111;
      4'h9: pattern = 7'b1111011;
      4'hA: pattern = 7'b1110111;
      4'hB: pattern = 7'b0011111;
      4'hC: pattern = 7'b1001110;
      4'hD: pattern = 7'b0111101;
      4'hE: pattern = 7'b1001111;
      4'hF: pattern = 7'b1000111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      an_act     <= '0;
      seg_act    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (enable && !blank) begin
        an_act  <= 8'd1 << digit_idx;
        seg_act <= pattern;
      end else begin
        an_act  <= '0;
        seg_act <= '0;
      end
    end
  end

  assign an  = ACTIVE_LOW ? ~an_act : an_act;
  assign seg = ACTIVE_LOW ? ~seg_act : seg_act;
  assign dp  = ACTIVE_LOW;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: active-high and active-low instances share
// stimulus and are compared each cycle against a frame-level reference model.
module tb_seven_seg_scan_driver;

  localparam int R  = 4;
  localparam int FR = 8 * R;

  localparam logic [6:0] PAT [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        load = 1'b0;
  logic [31:0] value = '0;
  logic        blank_lz = 1'b0;
  logic        enable = 1'b1;

  logic [6:0]  seg_hi, seg_lo;
  logic        dp_hi, dp_lo;
  logic [7:0]  an_hi, an_lo;
  logic        fd_hi, fd_lo;

  int checks = 0;
  int errors = 0;

  // Reference model: cycle count since reset plus the frame-level buffers.
  int          m_t = 0;
  logic [31:0] m_disp = '0;
  logic [31:0] m_pend = '0;
  bit          m_pv = 1'b0;
  logic [7:0]  e_an = '0;
  logic [6:0]  e_seg = '0;
  logic        e_fd = 1'b0;

  seven_seg_scan_driver #(.REFRESH_DIV(R), .ACTIVE_LOW(1'b0)) u_hi (
    .clk(clk), .clr(clr), .load(load), .value(value), .blank_lz(blank_lz),
    .enable(enable), .seg(seg_hi), .dp(dp_hi), .an(an_hi), .frame_done(fd_hi)
  );

  seven_seg_scan_driver #(.REFRESH_DIV(R), .ACTIVE_LOW(1'b1)) u_lo (
    .clk(clk), .clr(clr), .load(load), .value(value), .blank_lz(blank_lz),
    .enable(enable), .seg(seg_lo), .dp(dp_lo), .an(an_lo), .frame_done(fd_lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    int         digit;
    bit         bnd;
    logic [3:0] nib;
    @(posedge clk);
    if (clr) begin
      m_t = 0; m_disp = '0; m_pend = '0; m_pv = 1'b0;
      e_an = '0; e_seg = '0; e_fd = 1'b0;
    end else begin
      digit = (m_t / R) % 8;
      bnd   = (m_t % FR) == FR - 1;
      nib   = 4'((m_disp >> (4 * digit)) & 32'hF);
      if (!enable || (blank_lz && digit > 0 && (m_disp >> (4 * digit)) == 32'd0)) begin
        e_an = '0; e_seg = '0;
      end else begin
        e_an = 8'(1 << digit); e_seg = PAT[nib];
      end
      e_fd = bnd;
      if (bnd) begin
        if (load) begin
          m_disp = value; m_pend = value; m_pv = 1'b0;
        end else if (m_pv) begin
          m_disp = m_pend; m_pv = 1'b0;
        end
      end else if (load) begin
        m_pend = value; m_pv = 1'b1;
      end
      m_t++;
    end
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1; load = 1'b0; enable = 1'b1; blank_lz = 1'b0;
    tick(); tick();
    checks++;
    if (an_hi !== 8'h00 || seg_hi !== 7'h00 || dp_hi !== 1'b0 || fd_hi !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_hi: an=%h seg=%b dp=%b fd=%b, expected 00 0000000 0 0", an_hi, seg_hi, dp_hi, fd_hi);
    end
    checks++;
    if (an_lo !== 8'hFF || seg_lo !== 7'h7F || dp_lo !== 1'b1 || fd_lo !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_lo: an=%h seg=%b dp=%b fd=%b, expected ff 1111111 1 0", an_lo, seg_lo, dp_lo, fd_lo);
    end
  endtask

  task automatic test_scan();
    clr = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      tick();
      checks++;
      if (an_hi !== e_an || seg_hi !== e_seg || fd_hi !== e_fd) begin
        errors++;
        $display("[TB] FAIL scan k=%0d: an=%h seg=%b fd=%b, expected an=%h seg=%b fd=%b", k, an_hi, seg_hi, fd_hi, e_an, e_seg, e_fd);
      end
      checks++;
      if (fd_hi !== 1'((k % FR) == 0)) begin
        errors++;
        $display("[TB] FAIL scan_frame_pulse k=%0d: fd=%b, expected %b", k, fd_hi, (k % FR) == 0);
      end
    end
  endtask

  task automatic test_load_mid();
    bit new_frame = 1'b0;
    for (int i = 0; i < FR && (m_t % FR) != 10; i++) begin
      tick();
      checks++;
      if (an_hi !== e_an || seg_hi !== e_seg || fd_hi !== e_fd) begin
        errors++;
        $display("[TB] FAIL load_mid_align: an=%h seg=%b fd=%b, expected an=%h seg=%b fd=%b", an_hi, seg_hi, fd_hi, e_an, e_seg, e_fd);
      end
    end
    load = 1'b1; value = 32'h1234ABCD;
    tick();
    load = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (i > 0) tick();
      checks++;
      if (an_hi !== e_an || seg_hi !== e_seg || fd_hi !== e_fd) begin
        errors++;
        $display("[TB] FAIL load_mid: an=%h seg=%b fd=%b, expected an=%h seg=%b fd=%b", an_hi, seg_hi, fd_hi, e_an, e_seg, e_fd);
      end
      if (!new_frame && an_hi != 8'h00) begin
        checks++;
        if (seg_hi !== 7'b1111110) begin
          errors++;
          $display("[TB] FAIL load_mid_held: seg=%b, expected 1111110", seg_hi);
        end
      end
      if (new_frame && an_hi == 8'h01) begin
        checks++;
        if (seg_hi !== 7'b0111101) begin
          errors++;
          $display("[TB] FAIL load_mid_digit0: seg=%b, expected 0111101", seg_hi);
        end
      end
      if (new_frame && an_hi == 8'h80) begin
        checks++;
        if (seg_hi !== 7'b0110000) begin
          errors++;
          $display("[TB] FAIL load_mid_digit7: seg=%b, expected 0110000", seg_hi);
        end
      end
      if (fd_hi === 1'b1) new_frame = 1'b1;
    end
  endtask

  task automatic test_two_loads();
    bit after = 1'b0;
    for (int i = 0; i < FR && (m_t % FR) != 5; i++) begin
      tick();
      checks++;
      if (an_hi !== e_an || seg_hi !== e_seg || fd_hi !== e_fd) begin
        errors++;
        $display("[TB] FAIL two_loads_align: an=%h seg=%b fd=%b, expected an=%h seg=%b fd=%b", an_hi, seg_hi, fd_hi, e_an, e_seg, e_fd);
      end
    end
    load = 1'b1; value = 32'h11111111; tick();
    load = 1'b0; tick(); tick(); tick();
    load = 1'b1; value = 32'h22222222; tick();
    load = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if (an_hi !== e_an || seg_hi !== e_seg || fd_hi !== e_fd) begin
        errors++;
        $display("[TB] FAIL two_loads: an=%h seg=%b fd=%b, expected an=%h seg=%b fd=%b", an_hi, seg_hi, fd_hi, e_an, e_seg, e_fd);
      end
      if (after && an_hi != 8'h00) begin
        checks++;
        if (seg_hi !== 7'b1101101) begin
          errors++;
          $display("[TB] FAIL two_loads_last_wins: an=%h seg=%b, expected 1101101", an_hi, seg_hi);
        end
      end
      if (fd_hi === 1'b1) after = 1'b1;
    end
  endtask

  task automatic test_bypass();
    for (int i = 0; i < FR && (m_t % FR) != FR - 1; i++) begin
      tick();
      checks++;
      if (an_hi !== e_an || seg_hi !== e_seg || fd_hi !== e_fd) begin
        errors++;
        $display("[TB] FAIL bypass_align: an=%h seg=%b fd=%b, expected an=%h seg=%b fd=%b", an_hi, seg_hi, fd_hi, e_an, e_seg, e_fd);
      end
    end
    load = 1'b1; value = 32'h0000ABCD;
    tick();
    load = 1'b0;
    checks++;
    if (fd_hi !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bypass_boundary: fd=%b, expected 1", fd_hi);
    end
    tick();
    checks++;
    if (an_hi !== 8'h01 || seg_hi !== 7'b0111101) begin
      errors++;
      $display("[TB] FAIL bypass_digit0: an=%h seg=%b, expected 01 0111101", an_hi, seg_hi);
    end
    for (int i = 0; i < 2 * FR; i++) begin
      tick();
      checks++;
      if (an_hi !== e_an || seg_hi !== e_seg || fd_hi !== e_fd) begin
        errors++;
        $display("[TB] FAIL bypass_hold: an=%h seg=%b fd=%b, expected an=%h seg=%b fd=%b", an_hi, seg_hi, fd_hi, e_an, e_seg, e_fd);
      end
    end
  endtask

  task automatic test_blank();
    bit committed = 1'b0;
    blank_lz = 1'b1;
    load = 1'b1; value = 32'h000000F0; tick();
    load = 1'b0;
    for (int i = 0; i < 2 * FR; i++) begin
      tick();
      checks++;
      if (an_hi !== e_an || seg_hi !== e_seg || fd_hi !== e_fd) begin
        errors++;
        $display("[TB] FAIL blank_f0: an=%h seg=%b fd=%b, expected an=%h seg=%b fd=%b", an_hi, seg_hi, fd_hi, e_an, e_seg, e_fd);
      end
      if (committed) begin
        checks++;
        if ((an_hi & 8'hFC) !== 8'h00 || (an_hi == 8'h02 && seg_hi !== 7'b1000111)) begin
          errors++;
          $display("[TB] FAIL blank_f0_digits: an=%h seg=%b, expected only an 01/02 with digit1=1000111", an_hi, seg_hi);
        end
      end
      if (fd_hi === 1'b1) committed = 1'b1;
    end
    committed = 1'b0;
    load = 1'b1; value = 32'h00000000; tick();
    load = 1'b0;
    for (int i = 0; i < 2 * FR; i++) begin
      tick();
      checks++;
      if (an_hi !== e_an || seg_hi !== e_seg || fd_hi !== e_fd) begin
        errors++;
        $display("[TB] FAIL blank_zero: an=%h seg=%b fd=%b, expected an=%h seg=%b fd=%b", an_hi, seg_hi, fd_hi, e_an, e_seg, e_fd);
      end
      if (committed) begin
        checks++;
        if (!(an_hi == 8'h00 || (an_hi == 8'h01 && seg_hi == 7'b1111110))) begin
          errors++;
          $display("[TB] FAIL blank_zero_digits: an=%h seg=%b, expected 00 or 01 with 1111110", an_hi, seg_hi);
        end
      end
      if (fd_hi === 1'b1) committed = 1'b1;
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_active_low();
    enable = 1'b0;
    for (int i = 0; i < 70; i++) begin
      tick();
      checks++;
      if (an_lo !== 8'hFF || seg_lo !== 7'h7F || dp_lo !== 1'b1 || fd_lo !== e_fd) begin
        errors++;
        $display("[TB] FAIL disabled_lo: an=%h seg=%b dp=%b fd=%b, expected ff 1111111 1 fd=%b", an_lo, seg_lo, dp_lo, fd_lo, e_fd);
      end
    end
    enable = 1'b1;
    load = 1'b1; value = 32'h9E5C07A3; tick();
    load = 1'b0;
    for (int i = 0; i < 2 * FR; i++) begin
      tick();
      checks++;
      if (an_lo !== ~e_an || seg_lo !== ~e_seg || dp_lo !== 1'b1 || fd_lo !== e_fd) begin
        errors++;
        $display("[TB] FAIL active_low: an=%h seg=%b dp=%b fd=%b, expected an=%h seg=%b", an_lo, seg_lo, dp_lo, fd_lo, ~e_an, ~e_seg);
      end
    end
    for (int i = 0; i < FR && (m_t % FR) != 13; i++) tick();
    clr = 1'b1; tick();
    checks++;
    if (an_lo !== 8'hFF || seg_lo !== 7'h7F || fd_lo !== 1'b0 || an_hi !== 8'h00 || seg_hi !== 7'h00) begin
      errors++;
      $display("[TB] FAIL clr_mid_frame: an_lo=%h seg_lo=%b fd=%b an_hi=%h seg_hi=%b, expected ff 1111111 0 00 0000000", an_lo, seg_lo, fd_lo, an_hi, seg_hi);
    end
    clr = 1'b0; tick();
    checks++;
    if (an_hi !== 8'h01 || seg_hi !== 7'b1111110) begin
      errors++;
      $display("[TB] FAIL clr_restart: an=%h seg=%b, expected 01 1111110", an_hi, seg_hi);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      load  = ($urandom_range(0, 11) == 0);
      value = $urandom;
      if ($urandom_range(0, 3) == 0) value = value >> (4 * $urandom_range(1, 7));
      enable = ($urandom_range(0, 9) != 0);
      if ((i % 40) == 0) blank_lz = $urandom_range(0, 1) != 0;
      tick();
      checks++;
      if (an_hi !== e_an || seg_hi !== e_seg || fd_hi !== e_fd) begin
        errors++;
        $display("[TB] FAIL random_hi i=%0d: an=%h seg=%b fd=%b, expected an=%h seg=%b fd=%b", i, an_hi, seg_hi, fd_hi, e_an, e_seg, e_fd);
      end
      checks++;
      if (an_lo !== ~e_an || seg_lo !== ~e_seg || fd_lo !== e_fd || $countones(an_hi) > 1) begin
        errors++;
        $display("[TB] FAIL random_lo i=%0d: an=%h seg=%b fd=%b, expected an=%h seg=%b fd=%b", i, an_lo, seg_lo, fd_lo, ~e_an, ~e_seg, e_fd);
      end
    end
    load = 1'b0; enable = 1'b1; blank_lz = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load_mid();
    test_two_loads();
    test_bypass();
    test_blank();
    test_active_low();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
